// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer and the decode stage.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIX  = 2'b11
    } md_state_t;

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one step per cycle on a 2*WIDTH accumulator.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   i_lo_init,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH+1:0]   sub_diff;

    // Divide compares the shifted partial remainder (WIDTH+1 bits) against the
    // divisor, so the subtractor carries an extra sign bit.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        sub_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
        acc_next = acc;
        if (is_div) begin
            if (sub_diff[WIDTH+1]) begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc     <= {{WIDTH{1'b0}}, i_lo_init};
            operand <= i_operand;
        end else if (step) begin
            acc <= acc_next;
        end
    end

    assign o_acc = acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/DIV sequencer owning HI/LO: FSM, step counter, sign fix-up,
// divide-by-zero override and MTHI/MTLO writes.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_gl,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_t          state, state_next;
    md_op_t             op_q;
    logic [WIDTH-1:0]   rs_q, rt_q, hi_q, lo_q;
    logic [WIDTH-1:0]   abs_rs, abs_rt, quo, rem, hi_next, lo_next;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, prod;
    logic               neg_res, neg_rem, div_zero, done_q;
    logic               is_div, is_signed, neg_rs, neg_rt;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);
    assign neg_rs    = is_signed && rs_q[WIDTH-1];
    assign neg_rt    = is_signed && rt_q[WIDTH-1];
    assign abs_rs    = neg_rs ? -rs_q : rs_q;
    assign abs_rt    = neg_rt ? -rt_q : rt_q;

    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk_gl),
        .load      (state == ST_PREP),
        .step      (state == ST_CALC),
        .is_div    (is_div),
        .i_lo_init (is_div ? abs_rs : abs_rt),
        .i_operand (is_div ? abs_rt : abs_rs),
        .o_acc     (acc)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (i_start) state_next = ST_PREP;
            ST_PREP: state_next = ST_CALC;
            ST_CALC: if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (i_cancel && (state != ST_IDLE)) state_next = ST_IDLE;
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        {hi_next, lo_next} = prod;
        if (is_div) begin
            lo_next = neg_res ? -quo : quo;
            hi_next = neg_rem ? -rem : rem;
            if (div_zero) begin
                hi_next = rs_q;
                lo_next = '1;
            end
        end
    end

    always_ff @(posedge clk_gl) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk_gl) begin
        if (!rst) begin
            op_q     <= MD_MULT;
            rs_q     <= '0;
            rt_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == ST_FIX) && !i_cancel;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        op_q <= md_op_t'(i_op);
                        rs_q <= i_rs;
                        rt_q <= i_rt;
                    end else begin
                        if (i_mthi) hi_q <= i_wdata;
                        if (i_mtlo) lo_q <= i_wdata;
                    end
                end
                ST_PREP: begin
                    neg_res  <= neg_rs ^ neg_rt;
                    neg_rem  <= neg_rs;
                    div_zero <= is_div && (rt_q == '0);
                    cnt      <= CNT_W'(WIDTH - 1);
                end
                ST_CALC: if (cnt != '0) cnt <= cnt - 1'b1;
                ST_FIX: begin
                    if (!i_cancel) begin
                        hi_q <= hi_next;
                        lo_q <= lo_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
